// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-atomic sharing of one UART transmitter; UART_ARB_TAG_EN prefixes each packet with a source tag byte
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int BIT = 8,
  parameter int STALL_MAX = 1024,
  parameter logic [BIT-1:0] HDR_MARK = 8'hF0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ*BIT-1:0] req_data,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic [BIT-1:0]      tx_data,
  output logic                tx_data_valid,
  input  logic                tx_data_ready,
  output logic [NREQ-1:0]     grant,
  output logic                busy
);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_SEND, S_WAIT} state_t;
  state_t state, state_n;
  logic [NREQ-1:0] grant_n, win;
  logic [2:0] last_idx, last_idx_n, win_idx;
  logic [BIT-1:0] hold_data, hold_data_n, sel_data;
  logic hold_last, hold_last_n, found, take, sel_last;
  logic [15:0] stall_cnt, stall_cnt_n;
  assign req_ready = (state == S_LOAD) ? grant : '0;
  assign tx_data_valid = (state == S_SEND);
  assign tx_data = hold_data;
  assign busy = (state != S_IDLE);
  assign take = |(req_valid & req_ready);
  assign sel_last = |(req_last & grant);
  // rotating priority search starting just after the previous owner
  always_comb begin
    win = '0;
    win_idx = last_idx;
    found = 1'b0;
    sel_data = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req_valid[(int'(last_idx) + i) % NREQ]) begin
        found = 1'b1;
        win[(int'(last_idx) + i) % NREQ] = 1'b1;
        win_idx = 3'((int'(last_idx) + i) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) sel_data = sel_data | (req_data[i*BIT +: BIT] & {BIT{grant[i]}});
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_idx_n = last_idx;
    hold_data_n = hold_data;
    hold_last_n = hold_last;
    stall_cnt_n = stall_cnt;
    case (state)
      S_IDLE: if (found) begin
        grant_n = win;
        last_idx_n = win_idx;
        stall_cnt_n = '0;
`ifdef UART_ARB_TAG_EN
        state_n = S_HDR;
`else
        state_n = S_LOAD;
`endif
      end
      S_HDR: begin
        hold_data_n = HDR_MARK + BIT'(last_idx);
        hold_last_n = 1'b0;
        state_n = S_SEND;
      end
      S_LOAD: if (take) begin
        hold_data_n = sel_data;
        hold_last_n = sel_last;
        stall_cnt_n = '0;
        state_n = S_SEND;
      end else begin
        stall_cnt_n = stall_cnt + 16'd1;
        if (STALL_MAX != 0 && stall_cnt == 16'(STALL_MAX - 1)) begin
          grant_n = '0;
          stall_cnt_n = '0;
          state_n = S_IDLE;
        end
      end
      S_SEND: if (tx_data_ready) state_n = S_WAIT;
      // ready sampled low proves the transmitter took the byte and is shifting it
      S_WAIT: if (!tx_data_ready) begin
        if (hold_last) begin
          grant_n = '0;
          state_n = S_IDLE;
        end else begin
          stall_cnt_n = '0;
          state_n = S_LOAD;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      grant <= '0;
      last_idx <= 3'(NREQ - 1);
      hold_data <= '0;
      hold_last <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_idx <= last_idx_n;
      hold_data <= hold_data_n;
      hold_last <= hold_last_n;
      stall_cnt <= stall_cnt_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized packet traffic against a round-robin packet-order reference model
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [7:0] tx_data;
  logic tx_data_valid, busy;
  logic tx_data_ready = 1'b1;
  int tests = 0, fails = 0, mon_bad = 0, rr0_cnt = 0, txc = 0, rx_rd = 0;
  logic [8:0] rq [NREQ][256];
  int rh [NREQ], rt [NREQ], gap [NREQ];
  bit en [NREQ];
  bit gap_en = 1'b0, tx_hold = 1'b0;
  logic [11:0] rx_q [$], exp_q [$];

  uart_tx_arbiter #(.NREQ(NREQ), .BIT(8), .STALL_MAX(8), .HDR_MARK(8'hF0)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready), .grant(grant), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // requester side: present queue heads, pop on accept, optional mid-packet gaps
  initial begin
    logic [NREQ-1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          gap[i] = (!rq[i][rh[i]][8] && gap_en) ? int'($urandom_range(0, 3)) : 0;
          rh[i]++;
        end else if (gap[i] > 0) gap[i]--;
        req_valid[i] = en[i] && rh[i] < rt[i] && gap[i] == 0;
        req_data[i*8 +: 8] = rq[i][rh[i]][7:0];
        req_last[i] = rq[i][rh[i]][8];
      end
    end
  end

  // transmitter side: ready drops for a random shift time after each accepted byte
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = tx_data_valid && tx_data_ready && !rst;
      if (hs) rx_q.push_back({grant, tx_data});
      @(posedge clk);
      #1;
      if (hs) begin
        tx_data_ready = 1'b0;
        txc = int'($urandom_range(1, 5));
      end else if (txc > 0) txc--;
      else tx_data_ready = !tx_hold;
    end
  end

  always @(negedge clk) begin
    if (req_ready[0]) rr0_cnt++;
    if (!$onehot0(req_ready) || (req_ready & ~grant) != '0 || (tx_data_valid && !busy)) mon_bad++;
  end

  task automatic push(input int r, input logic [7:0] d, input bit last);
    rq[r][rt[r]] = {last, d};
    rt[r]++;
  endtask

  function automatic void exp_byte(input int r, input logic [7:0] d);
    exp_q.push_back({4'(1 << r), d});
  endfunction

  function automatic void exp_hdr(input int r);
    if (TAG) exp_byte(r, 8'hF0 + 8'(r));
  endfunction

  // expected stream: whole packets, owners taken in rotation after the previous owner
  task automatic model(input int ptr, output int last_owner);
    int h [NREQ];
    int p, j;
    bit any;
    p = ptr;
    for (int i = 0; i < NREQ; i++) h[i] = rh[i];
    do begin
      any = 1'b0;
      for (int k = 1; k <= NREQ && !any; k++) begin
        j = (p + k) % NREQ;
        if (h[j] < rt[j]) begin
          any = 1'b1;
          exp_hdr(j);
          do begin
            exp_byte(j, rq[j][h[j]][7:0]);
            h[j]++;
          end while (!rq[j][h[j]-1][8]);
          p = j;
        end
      end
    end while (any);
    last_owner = p;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (rx_q.size() - rx_rd < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk({tag, "_count"}, 32'(rx_q.size() - rx_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rx_rd < rx_q.size()) begin
      chk(tag, 32'(rx_q[rx_rd]), 32'(exp_q.pop_front()));
      rx_rd++;
    end
    exp_q.delete();
    rx_rd = rx_q.size();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
  endtask

  initial begin
    int n, base, owner, np, len;
    logic [7:0] d;
    for (int i = 0; i < NREQ; i++) en[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_valid", 32'(tx_data_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    // single 3-byte packet from requester 2
    push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
    exp_hdr(2); exp_byte(2, 8'h11); exp_byte(2, 8'h22); exp_byte(2, 8'h33);
    drain("t1");
    wait_idle("t1");
    // requesters 0 and 1 contend with 1-byte packets: strict alternation from 0
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom); push(0, d, 1); exp_hdr(0); exp_byte(0, d);
      d = 8'($urandom); push(1, d, 1); exp_hdr(1); exp_byte(1, d);
    end
    drain("t2");
    wait_idle("t2");
    // requester 3 arrives mid-packet of requester 1 and must wait for its last byte
    @(negedge clk);
    gap_en = 1'b1;
    en[3] = 1'b0;
    push(1, 8'hA1, 0); push(1, 8'hA2, 0); push(1, 8'hA3, 1);
    push(3, 8'hC1, 0); push(3, 8'hC2, 1);
    exp_hdr(1); exp_byte(1, 8'hA1); exp_byte(1, 8'hA2); exp_byte(1, 8'hA3);
    exp_hdr(3); exp_byte(3, 8'hC1); exp_byte(3, 8'hC2);
    n = 0;
    while (rx_q.size() <= rx_rd && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t3_first_byte_seen", 32'(rx_q.size() > rx_rd), 1);
    en[3] = 1'b1;
    drain("t3");
    wait_idle("t3");
    chk("t3_ready_outside_grant", 32'(mon_bad), 0);
    // stall timeout: byte without last, then no more data
    @(negedge clk);
    gap_en = 1'b0;
    base = rr0_cnt;
    push(0, 8'hA5, 0);
    exp_hdr(0); exp_byte(0, 8'hA5);
    drain("t4");
    wait_idle("t4");
    chk("t4_load_cycles", 32'(rr0_cnt - base), 9);
    // reset while stuck in send
    tx_hold = 1'b1;
    repeat (3) @(negedge clk);
    push(2, 8'h77, 1);
    n = 0;
    while (tx_data_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("t5_in_send", 32'(tx_data_valid), 1);
    chk("t5_no_handshake", 32'(rx_q.size() - rx_rd), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_grant", 32'(grant), 0);
    chk("t5_ready", 32'(req_ready), 0);
    chk("t5_tx_data", 32'(tx_data), 0);
    chk("t5_tx_valid", 32'(tx_data_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    tx_hold = 1'b0;
    // randomized rounds; priority pointer restarts at NREQ-1 after reset
    owner = NREQ - 1;
    gap_en = 1'b1;
    for (int round = 0; round < 3; round++) begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) begin
        np = int'($urandom_range(0, 3));
        for (int p = 0; p < np; p++) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
        end
      end
      model(owner, owner);
      drain("t6");
      wait_idle("t6");
    end
    chk("monitor_violations", 32'(mon_bad), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between `NREQ` byte-stream requesters. Each requester offers packets as byte sequences, with the final byte marked by `req_last`. The arbiter grants one requester at a time and holds that grant for the whole packet, so packets never interleave on the serial line. It sits between the per-source producers (debug, status, trace) and the transmitter's `tx_data`/`tx_data_valid`/`tx_data_ready` interface.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `BIT`, 8: data word width; must match the transmitter.
- `STALL_MAX`, 1024: cycles a granted requester may leave `req_valid` low mid-packet before its grant is revoked. 0 disables the timeout.
- `HDR_MARK`, 8'hF0: base value of the tag header byte (used only with `UART_ARB_TAG_EN`).
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_data`  in  NREQ*BIT  packed data; requester i occupies `[i*BIT +: BIT]`.
- `req_valid`  in  NREQ  requester i has a byte available.
- `req_last`  in  NREQ  the offered byte is the last byte of its packet.
- `req_ready`  out  NREQ  byte accept strobe; at most one bit is high.
- `tx_data`  out  BIT  byte presented to the transmitter.
- `tx_data_valid`  out  1  byte request to the transmitter.
- `tx_data_ready`  in  1  transmitter is idle and can accept a byte.
- `grant`  out  NREQ  one-hot current owner; all zero when no requester owns the arbiter.
- `busy`  out  1  high in any state other than S_IDLE.

## Operation
- Registers:
  - `state` (S_IDLE, S_HDR, S_LOAD, S_SEND, S_WAIT).
  - `grant`.
  - `last_idx`: round-robin pointer, 3 bits.
  - `hold_data`, `hold_last`.
  - 16-bit `stall_cnt`.
- Arbitration (S_IDLE):
  - Scan indices `last_idx+1 … last_idx+NREQ`, mod NREQ. The first index with `req_valid` set wins.
  - Winner is registered: `grant` is set to the one-hot winner and `last_idx` to the winner's index.
  - Next state is S_HDR if `UART_ARB_TAG_EN` is defined, otherwise S_LOAD.
  - If no `req_valid` is set, remain in S_IDLE.
- S_HDR: `hold_data` ← `HDR_MARK + idx` (BIT bits, modulo 2^BIT); `hold_last` ← 0; go to S_SEND.
- S_LOAD:
  - `req_ready` = `grant` (combinational from `state` and `grant`).
  - On `req_valid[g] && req_ready[g]`: `hold_data` ← requester g's data, `hold_last` ← `req_last[g]`, `stall_cnt` ← 0, go to S_SEND.
  - Otherwise `stall_cnt` increments.
  - If `STALL_MAX != 0` and `stall_cnt == STALL_MAX-1`: `grant` ← 0, go to S_IDLE. The packet is abandoned.
- S_SEND:
  - `tx_data_valid` = 1 and `tx_data` = `hold_data`.
  - Handshake occurs in a cycle where `tx_data_ready` = 1; the next state is S_WAIT.
  - With `tx_data_ready` = 0, remain in S_SEND indefinitely; no timeout applies.
- S_WAIT:
  - `tx_data_valid` = 0.
  - Wait for `tx_data_ready` to be sampled 0, which confirms the transmitter left idle.
  - Then: if `hold_last`, set `grant` ← 0 and go to S_IDLE; else reset `stall_cnt` to 0 and go to S_LOAD.
- Requesters other than the granted one never see `req_ready`, whatever their `req_valid`.
- Pipelining: the next byte is loaded in S_LOAD while the transmitter is still shifting the previous byte.

## Timing
- Reset values: `state` = S_IDLE, `grant` = 0, `last_idx` = NREQ-1 (requester 0 has priority first), `req_ready` = 0, `tx_data` = 0, `tx_data_valid` = 0, `busy` = 0, `stall_cnt` = 0.
- Latency without tag:
  - `req_valid` high at cycle n in S_IDLE → `grant` and `req_ready` high at n+1.
  - Byte accepted at n+1 if still valid.
  - `tx_data_valid` high from n+2.
- The tag adds 1 cycle before the header's S_SEND. The data byte follows after the header's S_WAIT.
- `tx_data_valid` is high only in S_SEND. It drops the cycle after the handshake.
- Reset asserted mid-packet: every register returns to its reset value on the next edge. The packet is dropped with no header retransmit.
- `tx_data_ready` held at 1 in S_WAIT: the arbiter stalls. This is legal, and the transmitter always drops ready after accepting a byte.

## Configuration
- `UART_ARB_TAG_EN` defined: every granted packet is preceded by one header byte `HDR_MARK + idx`, which lets the receiver demultiplex sources.
- `UART_ARB_TAG_EN` undefined: S_HDR is never entered and only payload bytes are sent; `HDR_MARK` is unused.

## Test plan
- Reset, then requester 2 sends a 3-byte packet 0x11,0x22,0x33 (last on 0x33) → exactly 3 handshakes in that order, `grant` = 4'b0100 throughout, then `grant` = 0 and `busy` = 0.
- Requesters 0 and 1 both valid from reset, each sending 1-byte packets repeatedly → grants alternate 0,1,0,1. No requester is granted twice in a row while the other is valid.
- Requester 1 is mid-packet when requester 3 asserts `req_valid` → requester 3 gets no `req_ready` until requester 1's `req_last` byte completes; requester 3 is granted next.
- `STALL_MAX` = 8; granted requester drops `req_valid` after its first byte → grant revoked after 8 cycles in S_LOAD and `busy` falls.
- With `UART_ARB_TAG_EN`, requester 3 sends 0x5A (last) → transmitter receives 0xF3, then 0x5A.
- Assert `rst` while in S_SEND with `tx_data_ready` = 0 → next cycle all outputs are at their reset values, and a new packet is then arbitrated normally.
